// File: rtl/load_store_unit.sv
// Memory-access stage: runs one data-memory transaction per start over a
// req/ack handshake, stalls the core while busy, and returns the extended
// load value. Illegal or misaligned accesses fault without touching memory.
// A fault holds FAULT for two cycles and pulses done in the second, so a
// start-time fault completes at the same cycle offset as the fastest access.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  state_t        state, state_nxt;
  logic          st_q;
  logic [2:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic          fault_hold_q;
  logic          mis_q;
  logic          err_q;
  logic          illegal;
  logic          misal;
  logic [31:0]   byte_sh;
  logic [31:0]   half_sh;
  logic [31:0]   load_ext;

  // Classify the access presented with start; only consulted in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    illegal = 1'b0;
    misal   = 1'b0;
    if (mem_op == 3'b010 || mem_op[2:1] == 2'b11 || (is_store && mem_op[2]))
      illegal = 1'b1;
    else if ((mem_op[1:0] == 2'b01 && addr[0]) ||
             (mem_op[1:0] == 2'b11 && addr[1:0] != 2'b00))
      misal = 1'b1;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (illegal || misal) ? FAULT : REQ;
      REQ:   if (dm_ack) state_nxt = RESP;
             else if (cnt_q == CW'(TIMEOUT_CYC - 1)) state_nxt = FAULT;
      RESP:  state_nxt = IDLE;
      FAULT: if (fault_hold_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign dm_req   = (state == REQ);
  assign done     = (state == RESP) || (state == FAULT && fault_hold_q);
  assign misalign = (state == FAULT) && fault_hold_q && mis_q;
  assign bus_err  = (state == FAULT) && fault_hold_q && err_q;
  assign dm_we    = (state == REQ) && st_q;
  assign dm_addr  = {addr_q[31:2], 2'b00};

  // Byte enables and lane-replicated store data from the latched access.
  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = wdata_q;
    case (op_q[1:0])
      2'b00: begin
        dm_be    = 4'b0001 << addr_q[1:0];
        dm_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{wdata_q[15:0]}};
      end
      default: dm_be = 4'b1111;
    endcase
    if (state != REQ) dm_be = 4'b0000;
  end

  // Select the addressed lane of the read word and sign/zero-extend it.
  always_comb begin
    byte_sh  = dm_rdata >> {addr_q[1:0], 3'b000};
    half_sh  = dm_rdata >> {addr_q[1], 4'b0000};
    load_ext = dm_rdata;
    case (op_q[1:0])
      2'b00:   load_ext = {{24{~op_q[2] & byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   load_ext = {{16{~op_q[2] & half_sh[15]}}, half_sh[15:0]};
      default: load_ext = dm_rdata;
    endcase
  end

  // State register, access latch, timeout counter and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      st_q         <= 1'b0;
      op_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      fault_hold_q <= 1'b0;
      mis_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= state_nxt;
      fault_hold_q <= (state == FAULT) && !fault_hold_q;
      cnt_q        <= (state == REQ) ? cnt_q + 1'b1 : '0;
      if (state == IDLE && start) begin
        st_q    <= is_store;
        op_q    <= mem_op;
        addr_q  <= addr;
        wdata_q <= wdata;
        mis_q   <= misal;
        err_q   <= illegal;
      end
      if (state == REQ && !dm_ack && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        mis_q <= 1'b0;
        err_q <= 1'b1;
      end
      if (state == REQ && dm_ack && !st_q)
        rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: the bench plays the data memory,
// pushes each access's expected outcome to a scoreboard queue at issue time
// and pops/compares it when done appears.
module tb_load_store_unit;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misalign, bus_err;
  logic [31:0] rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_rdata = '0;

  typedef struct {
    int          done_cyc;
    int          reqs;
    logic        mis;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  load_store_unit #(.TIMEOUT_CYC(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misalign(misalign), .bus_err(bus_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Reference little-endian load extraction.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Issue one access, act as memory (ack on request cycle ack_at, 0 = never),
  // and compare bus fields each request cycle and the outcome at done.
  task automatic do_access(input string name, input logic st, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rword, input bit glitch);
    exp_t        e, got;
    logic        ill, mis;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          c, reqn;
    bit          seen;
    ill = (op == 3'b010) || (op[2:1] == 2'b11) || (st && op[2]);
    mis = !ill && ((op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b11 && a[1:0] != 2'b00));
    case (op[1:0])
      2'b00: begin
        ebe = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
              (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
        ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end
      2'b01: begin
        ebe = a[1] ? 4'b1100 : 4'b0011;
        ewd = {wd[15:0], wd[15:0]};
      end
      default: begin
        ebe = 4'b1111;
        ewd = wd;
      end
    endcase
    e.mis = mis;
    e.err = ill;
    e.rd  = model_rdata;
    if (ill || mis) begin
      e.done_cyc = 2; e.reqs = 0;
    end else if (ack_at == 0) begin
      e.done_cyc = N + 2; e.reqs = N; e.err = 1'b1;
    end else begin
      e.done_cyc = ack_at + 1; e.reqs = ack_at;
      if (!st) e.rd = ref_load(op, a[1:0], rword);
    end
    model_rdata = e.rd;
    exp_q.push_back(e);

    @(posedge clk); #1;
    start = 1'b1; is_store = st; mem_op = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; is_store = 1'b0; mem_op = 3'b011; addr = 32'hFFFF_FFFF; wdata = '0;
    c = 1; reqn = 0; seen = 0;
    while (!seen && c < 100) begin
      if (glitch && c == 2) begin
        start = 1'b1; is_store = ~st; mem_op = 3'b000; addr = 32'h0000_0F01; wdata = 32'h5555_5555;
      end
      if (glitch && c == 3) start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL %s busy cyc=%0d got=%b want=1", name, c, busy);
      end
      if (done === 1'b1) begin
        seen = 1;
        got.done_cyc = c; got.reqs = reqn; got.mis = misalign; got.err = bus_err; got.rd = rdata;
        e = exp_q.pop_front();
        checks++;
        if (got.done_cyc != e.done_cyc || got.reqs != e.reqs) begin
          failures++;
          $display("FAIL %s latency got done=%0d reqs=%0d want done=%0d reqs=%0d",
                   name, got.done_cyc, got.reqs, e.done_cyc, e.reqs);
        end
        checks++;
        if ({got.mis, got.err} !== {e.mis, e.err}) begin
          failures++;
          $display("FAIL %s flags got mis=%b err=%b want mis=%b err=%b",
                   name, got.mis, got.err, e.mis, e.err);
        end
        checks++;
        if (got.rd !== e.rd) begin
          failures++; $display("FAIL %s rdata got=%h want=%h", name, got.rd, e.rd);
        end
      end else begin
        if (dm_req === 1'b1) begin
          reqn++;
          checks++;
          if ({dm_we, dm_addr, dm_be, dm_wdata} !== {st, a[31:2], 2'b00, ebe, ewd}) begin
            failures++;
            $display("FAIL %s bus cyc=%0d got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                     name, c, dm_we, dm_addr, dm_be, dm_wdata, st, {a[31:2], 2'b00}, ebe, ewd);
          end
          if (reqn == ack_at) begin
            dm_ack = 1'b1; dm_rdata = rword;
          end
        end
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = $urandom;
        c++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s no done within %0d cycles", name, c);
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, dm_req, done} !== 3'b000) begin
      failures++; $display("FAIL %s idle-after got=%b want=000", name, {busy, dm_req, done});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, misalign, bus_err, dm_req, dm_we, dm_be, rdata} !== '0) begin
      failures++;
      $display("FAIL reset outputs got busy=%b done=%b req=%b be=%b rdata=%h want zeros",
               busy, done, dm_req, dm_be, rdata);
    end
  endtask

  task automatic test_loads();
    do_access("lw",      1'b0, 3'b011, 32'h0000_0100, '0, 4, 32'hDEAD_BEEF, 0);
    do_access("lb",      1'b0, 3'b000, 32'h0000_0103, '0, 2, 32'h80FF_0000, 0);
    do_access("lbu",     1'b0, 3'b100, 32'h0000_0103, '0, 1, 32'h80FF_0000, 0);
    do_access("lh",      1'b0, 3'b001, 32'h0000_0102, '0, 3, 32'h8001_7777, 0);
    do_access("lhu",     1'b0, 3'b101, 32'h0000_0100, '0, 1, 32'h1234_F00D, 0);
    do_access("lb_pos",  1'b0, 3'b000, 32'h0000_0201, '0, 2, 32'h0000_7F00, 0);
  endtask

  task automatic test_stores();
    do_access("sh",  1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 2, '0, 0);
    do_access("sb",  1'b1, 3'b000, 32'h0000_0041, 32'h0000_00EF, 1, '0, 0);
    do_access("sw",  1'b1, 3'b011, 32'h0000_0080, 32'hCAFE_F00D, 3, '0, 0);
  endtask

  task automatic test_faults();
    do_access("lw_mis",   1'b0, 3'b011, 32'h0000_0102, '0, 1, 32'h1111_1111, 0);
    do_access("sh_mis",   1'b1, 3'b001, 32'h0000_0021, 32'h1, 1, '0, 0);
    do_access("op010",    1'b0, 3'b010, 32'h0000_0000, '0, 1, '0, 0);
    do_access("st_u",     1'b1, 3'b100, 32'h0000_0000, '0, 1, '0, 0);
    do_access("op110mis", 1'b0, 3'b110, 32'h0000_0001, '0, 1, '0, 0);
  endtask

  task automatic test_timeout();
    do_access("timeout", 1'b0, 3'b011, 32'h0000_0300, '0, 0, '0, 0);
  endtask

  task automatic test_back_to_back();
    do_access("glitch_lw", 1'b0, 3'b011, 32'h0000_0400, '0, 3, 32'h0BAD_F00D, 1);
    do_access("next_lhu",  1'b0, 3'b101, 32'h0000_0402, '0, 1, 32'hABCD_0000, 0);
  endtask

  task automatic test_reset_mid();
    int dones;
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; mem_op = 3'b011; addr = 32'h0000_0500;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_rdata = '0;
    checks++;
    if ({dm_req, busy, done} !== 3'b000) begin
      failures++; $display("FAIL rst_mid drop got=%b want=000", {dm_req, busy, done});
    end
    checks++;
    if (rdata !== model_rdata) begin
      failures++; $display("FAIL rst_mid rdata got=%h want=%h", rdata, model_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dm_ack = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || dm_req === 1'b1) dones++;
    end
    dm_ack = 1'b0;
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL rst_mid activity got=%0d want=0", dones);
    end
  endtask

  initial begin
    #22 rst_n = 1'b1;
    #1;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
